// File: rtl/arbitro_memoria_datos.sv
// Arbiter sharing the single-port data memory between the CPU load/store path and the video fetch unit.
// Optional anti-starvation for the video side is enabled with `define ARBITRO_ANTIHAMBRE_EN.
module arbitro_memoria_datos #(
  parameter int ANCHO_DIR  = 32,
  parameter int ANCHO_DATO = 32,
  parameter int LATENCIA   = 1,
  parameter int MAX_ESPERA = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  cpuReq,
  input  logic                  cpuWr,
  input  logic [ANCHO_DIR-1:0]  cpuDirec,
  input  logic [ANCHO_DATO-1:0] cpuDatoIn,
  output logic                  cpuGnt,
  output logic                  cpuValido,
  output logic [ANCHO_DATO-1:0] cpuDato,
  input  logic                  vgaReq,
  input  logic [ANCHO_DIR-1:0]  vgaDirec,
  output logic                  vgaGnt,
  output logic                  vgaValido,
  output logic [ANCHO_DATO-1:0] vgaDato,
  output logic [ANCHO_DIR-1:0]  memDirec,
  output logic [ANCHO_DATO-1:0] memDatoOut,
  output logic                  memWr,
  output logic                  memRd,
  input  logic [ANCHO_DATO-1:0] memDatoIn,
  output logic                  ocupado
);

  if (LATENCIA < 1 || LATENCIA > 4 || MAX_ESPERA < 1) begin : g_param_chk
    $error("arbitro_memoria_datos: LATENCIA must be 1..4 and MAX_ESPERA >= 1");
  end

  typedef enum logic [1:0] {LIBRE, ACCESO, ESPERA} estado_t;

  localparam int CW = $clog2(LATENCIA + 1);

  estado_t               estado_q, estado_d;
  logic [CW-1:0]         cuenta_q, cuenta_d;
  logic [ANCHO_DIR-1:0]  dir_q, dir_d;
  logic [ANCHO_DATO-1:0] wdato_q, wdato_d;
  logic                  wr_q, wr_d;
  logic                  es_vga_q, es_vga_d;
  logic                  cpu_valido_q, cpu_valido_d;
  logic                  vga_valido_q, vga_valido_d;
  logic [ANCHO_DATO-1:0] cpu_dato_q, cpu_dato_d;
  logic [ANCHO_DATO-1:0] vga_dato_q, vga_dato_d;
  logic                  gana_vga;

`ifdef ARBITRO_ANTIHAMBRE_EN
  localparam int HW = $clog2(MAX_ESPERA + 1);
  logic [HW-1:0] hambre_q, hambre_d;

  // Counts CPU grants the video side has sat through; any video grant or idle video side clears it.
  always_comb begin
    hambre_d = hambre_q;
    if (!vgaReq || vgaGnt)
      hambre_d = '0;
    else if (cpuGnt && hambre_q != HW'(MAX_ESPERA))
      hambre_d = hambre_q + HW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetN) hambre_q <= '0;
    else         hambre_q <= hambre_d;
  end

  assign gana_vga = vgaReq && (!cpuReq || hambre_q == HW'(MAX_ESPERA));
`else
  assign gana_vga = vgaReq && !cpuReq;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    estado_d     = estado_q;
    cuenta_d     = cuenta_q;
    dir_d        = dir_q;
    wdato_d      = wdato_q;
    wr_d         = wr_q;
    es_vga_d     = es_vga_q;
    cpu_valido_d = 1'b0;
    vga_valido_d = 1'b0;
    cpu_dato_d   = cpu_dato_q;
    vga_dato_d   = vga_dato_q;
    case (estado_q)
      LIBRE: begin
        if (cpuReq || vgaReq) begin
          es_vga_d = gana_vga;
          dir_d    = gana_vga ? vgaDirec : cpuDirec;
          wdato_d  = gana_vga ? wdato_q : cpuDatoIn;
          wr_d     = !gana_vga && cpuWr;
          estado_d = ACCESO;
        end
      end
      ACCESO: begin
        if (wr_q) begin
          cpu_valido_d = 1'b1;
          estado_d     = LIBRE;
        end else begin
          cuenta_d = CW'(LATENCIA);
          estado_d = ESPERA;
        end
      end
      ESPERA: begin
        cuenta_d = cuenta_q - CW'(1);
        if (cuenta_q == CW'(1)) begin
          estado_d = LIBRE;
          if (es_vga_q) begin
            vga_valido_d = 1'b1;
            vga_dato_d   = memDatoIn;
          end else begin
            cpu_valido_d = 1'b1;
            cpu_dato_d   = memDatoIn;
          end
        end
      end
      default: estado_d = LIBRE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      // NOTE: the datapath copies are reset too because they drive outputs that must read 0 in reset.
      estado_q     <= LIBRE;
      cuenta_q     <= '0;
      dir_q        <= '0;
      wdato_q      <= '0;
      wr_q         <= 1'b0;
      es_vga_q     <= 1'b0;
      cpu_valido_q <= 1'b0;
      vga_valido_q <= 1'b0;
      cpu_dato_q   <= '0;
      vga_dato_q   <= '0;
    end else begin
      estado_q     <= estado_d;
      cuenta_q     <= cuenta_d;
      dir_q        <= dir_d;
      wdato_q      <= wdato_d;
      wr_q         <= wr_d;
      es_vga_q     <= es_vga_d;
      cpu_valido_q <= cpu_valido_d;
      vga_valido_q <= vga_valido_d;
      cpu_dato_q   <= cpu_dato_d;
      vga_dato_q   <= vga_dato_d;
    end
  end

  assign cpuGnt     = (estado_q == ACCESO) && !es_vga_q;
  assign vgaGnt     = (estado_q == ACCESO) && es_vga_q;
  assign memWr      = (estado_q == ACCESO) && wr_q;
  assign memRd      = (estado_q == ACCESO) && !wr_q;
  assign memDirec   = dir_q;
  assign memDatoOut = wdato_q;
  assign cpuValido  = cpu_valido_q;
  assign vgaValido  = vga_valido_q;
  assign cpuDato    = cpu_dato_q;
  assign vgaDato    = vga_dato_q;
  assign ocupado    = (estado_q != LIBRE);

endmodule
